matrix_fetch: RTL and testbench
===============================

# matrix_fetch

Responder side of the row/column request handshake used by `iter_control`. It accepts a (row, column) request, streams the matching row of matrix A and column of matrix B out of two synchronous-read BRAMs, and returns both as packed 32-element vectors with a one-cycle `val_rows` strobe. It sits between the matrix storage BRAMs and `iter_control`. Its response ports connect one-to-one to `iter_control`'s `matA_row`, `matB_col`, `val_rows`, `row_in` and `col_in`.

## Interface
- `N`, 32: matrix dimension; elements per vector.
- `DW`, 8: element width in bits.
- `IDXW`, 6: request index width.
- `AW`, 10: BRAM address width; must satisfy 2^AW ≥ N*N.
- `RD_LAT`, 2: BRAM read latency in cycles; legal range is 1 to 4.

- `clk_in` in 1: single clock; all logic is on the rising edge.
- `rst_in` in 1: reset, asynchronous and active-low.
- `new_request` in 1: request strobe; accepted only when `req_ready`=1.
- `row_req` in IDXW: row index into A.
- `col_req` in IDXW: column index into B.
- `req_ready` out 1: block is idle and can accept a request.
- `a_addr` out AW: A BRAM address, row-major (`row*N + k`).
- `a_rd_en` out 1: A read enable.
- `a_data` in DW: A read data, valid RD_LAT cycles after `a_rd_en`.
- `b_addr` out AW: B BRAM address, row-major (`k*N + col`).
- `b_rd_en` out 1: B read enable.
- `b_data` in DW: B read data, valid RD_LAT cycles after `b_rd_en`.
- `matA_row` out [N-1:0][DW-1:0]: `matA_row[k]` = A[row][k].
- `matB_col` out [N-1:0][DW-1:0]: `matB_col[k]` = B[k][col].
- `val_rows` out 1: one-cycle strobe; both vectors and the tags are valid.
- `row_resp` out IDXW: echoed row tag for the response.
- `col_resp` out IDXW: echoed column tag for the response.

## Operation
- States:
  - IDLE → ISSUE on `new_request && req_ready`. Latch the row and column, clear the address counter k.
  - ISSUE: drive `a_rd_en`/`b_rd_en`=1 and addresses for k = 0..N-1, one per cycle. After k=N-1 go to DRAIN.
  - DRAIN: wait until the read pipeline is empty (RD_LAT cycles), then go to RESP.
  - RESP: `val_rows`=1 for exactly one cycle, then IDLE.
- `req_ready`=1 only in IDLE.
  - `new_request` outside IDLE is ignored and not queued.
  - Row/column inputs are don't-care when `new_request`=0.
- Read pipeline: an RD_LAT-deep shift of {valid, k}. When a returned beat has valid=1, write `a_data` into `matA_row[k]` and `b_data` into `matB_col[k]`.
- Out-of-range index (≥ N):
  - A row index ≥ N suppresses `a_rd_en` for the whole request and writes zeros into `matA_row`. A column index ≥ N does the same for B.
  - Latency is unchanged.
  - Tags are echoed as received.
- Output data lifetime:
  - Vectors and tags are valid while `val_rows`=1.
  - They hold until the first capture of the next accepted request.
  - Tags update in RESP.
- Reset (`rst_in`=0, at any time, including mid-fetch):
  - State returns to IDLE; k and pipeline valids clear.
  - Vectors, tags and addresses reset to 0; `val_rows`=0, `a_rd_en`/`b_rd_en`=0.
  - BRAM data still in flight is discarded.
- Addresses are computed as `row*N+k` truncated to AW bits. N is a power of two, so this reduces to concatenation.

## Timing
- Request accepted at cycle 0.
- Element k is issued at cycle 1+k and captured at cycle 1+k+RD_LAT.
- `val_rows` is high at cycle N+RD_LAT+1; for the defaults that is cycle 35.
- `req_ready` is 0 from cycle 1 through N+RD_LAT+1, and returns to 1 at N+RD_LAT+2.
- Back-to-back requests: a request held high through RESP is accepted the cycle `req_ready` rises. Throughput is one response per N+RD_LAT+2 cycles.
- Reset values:
  - `req_ready`=1 once reset releases; 0 is also acceptable while `rst_in` is low.
  - Every other output is 0.

## Structure
- Package `matrix_pkg` holds:
  - N, DW, IDXW, AW;
  - `elem_t` (logic [DW-1:0]) and `vec_t` (logic [N-1:0][DW-1:0]);
  - the state enum `fetch_state_t` {IDLE, ISSUE, DRAIN, RESP}.
- One sub-module, `mat_fetch_pipe`: the RD_LAT-deep {valid, k} delay line with async active-low clear.
- Top level contains the FSM, address generation and capture registers.

## Test plan
- Reset, then request (row 2, col 5) against BRAM models preloaded with A[r][c]=r*N+c and B[r][c]=c+1, RD_LAT=2 → `val_rows` pulses once at cycle 35; `matA_row[k]`=64+k; `matB_col[k]`=6; `row_resp`=2, `col_resp`=5.
- Identity B with col 0 → `matB_col[0]`=1 and every other element 0. All-ones A → all 32 `matA_row` elements are 8'h01.
- Request (row 40, col 3) → `a_rd_en` never asserts; `matA_row` is all 0; B column is correct; `val_rows` still at cycle 35.
- `new_request` pulsed repeatedly with other indices while busy → ignored. The response carries the first tags only, and exactly one `val_rows` pulse occurs.
- Assert `rst_in`=0 at cycle 12 of a fetch, release, then issue a new request (row 1, col 1) → no stale `val_rows`; outputs are 0 during reset; the new response is correct at cycle 35 after its acceptance.
- Hold `new_request` high continuously → responses arrive 36 cycles apart (N+RD_LAT+2 = 36) with correct tags.

Source files
------------

// File: rtl/matrix_fetch_pkg.sv
// rtl/matrix_fetch_pkg.sv - shared sizes, element/vector types and fetch FSM states.
package matrix_pkg;
  localparam int N    = 32;
  localparam int DW   = 8;
  localparam int IDXW = 6;
  localparam int AW   = 10;
  localparam int KW   = $clog2(N);

  typedef logic [DW-1:0]         elem_t;
  typedef logic [N-1:0][DW-1:0]  vec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } fetch_state_t;
endpackage

// File: rtl/matrix_fetch_if.sv
// rtl/matrix_fetch_if.sv - request/response handshake plus A/B BRAM read ports.
interface matrix_fetch_if;
  import matrix_pkg::*;

  logic             new_request;
  logic [IDXW-1:0]  row_req;
  logic [IDXW-1:0]  col_req;
  logic             req_ready;
  logic [AW-1:0]    a_addr;
  logic             a_rd_en;
  elem_t            a_data;
  logic [AW-1:0]    b_addr;
  logic             b_rd_en;
  elem_t            b_data;
  vec_t             matA_row;
  vec_t             matB_col;
  logic             val_rows;
  logic [IDXW-1:0]  row_resp;
  logic [IDXW-1:0]  col_resp;

  modport slave (
    input  new_request, row_req, col_req, a_data, b_data,
    output req_ready, a_addr, a_rd_en, b_addr, b_rd_en,
           matA_row, matB_col, val_rows, row_resp, col_resp
  );

  modport master (
    output new_request, row_req, col_req, a_data, b_data,
    input  req_ready, a_addr, a_rd_en, b_addr, b_rd_en,
           matA_row, matB_col, val_rows, row_resp, col_resp
  );
endinterface

// File: rtl/matrix_fetch_pipe.sv
// rtl/matrix_fetch_pipe.sv - RD_LAT-deep {valid, k} delay line aligned with BRAM read data.
module mat_fetch_pipe #(
  parameter int RD_LAT = 2,
  parameter int KW     = 5
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  input  logic [KW-1:0] in_k,
  output logic          out_valid,
  output logic [KW-1:0] out_k
);
  logic [RD_LAT-1:0]         v;
  logic [RD_LAT-1:0][KW-1:0] kq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v  <= '0;
      kq <= '0;
    end else begin
      v[0]  <= in_valid;
      kq[0] <= in_k;
      for (int i = 1; i < RD_LAT; i++) begin
        v[i]  <= v[i-1];
        kq[i] <= kq[i-1];
      end
    end
  end

  assign out_valid = v[RD_LAT-1];
  assign out_k     = kq[RD_LAT-1];
endmodule

// File: rtl/matrix_fetch.sv
// rtl/matrix_fetch.sv - fetches row A[row][*] and column B[*][col] from BRAM into packed vectors.
module matrix_fetch
  import matrix_pkg::*;
#(
  parameter int RD_LAT = 2
) (
  input  logic          clk_in,
  input  logic          rst_in,
  matrix_fetch_if.slave bus
);
  localparam int CW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CW-1:0] DRAIN_LAST = CW'(RD_LAT - 1);
  localparam logic [KW-1:0] K_LAST     = KW'(N - 1);

  fetch_state_t    state, state_nx;
  logic [KW-1:0]   k;
  logic [CW-1:0]   drain_cnt;
  logic [IDXW-1:0] row_q, col_q, row_tag, col_tag;
  logic            a_oob, b_oob;
  vec_t            a_vec, b_vec;
  logic            issue, accept;
  logic            p_valid;
  logic [KW-1:0]   p_k;

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        accept = bus.new_request;
        if (bus.new_request) state_nx = ISSUE;
      end
      ISSUE: begin
        issue = 1'b1;
        if (k == K_LAST) state_nx = DRAIN;
      end
      DRAIN: if (drain_cnt == DRAIN_LAST) state_nx = RESP;
      RESP:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state <= IDLE;
    else         state <= state_nx;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      k         <= '0;
      drain_cnt <= '0;
      row_q     <= '0;
      col_q     <= '0;
      a_oob     <= 1'b0;
      b_oob     <= 1'b0;
      row_tag   <= '0;
      col_tag   <= '0;
      a_vec     <= '0;
      b_vec     <= '0;
    end else begin
      if (accept) begin
        row_q <= bus.row_req;
        col_q <= bus.col_req;
        a_oob <= bus.row_req >= IDXW'(N);
        b_oob <= bus.col_req >= IDXW'(N);
        k     <= '0;
      end
      if (issue) begin
        k         <= k + 1'b1;
        drain_cnt <= '0;
      end
      if (state == DRAIN) begin
        drain_cnt <= drain_cnt + 1'b1;
        if (drain_cnt == DRAIN_LAST) begin
          row_tag <= row_q;
          col_tag <= col_q;
        end
      end
      // Out-of-range sides still walk the pipeline so latency is unchanged; they just write zeros.
      if (p_valid) begin
        a_vec[p_k] <= a_oob ? '0 : bus.a_data;
        b_vec[p_k] <= b_oob ? '0 : bus.b_data;
      end
    end
  end

  mat_fetch_pipe #(.RD_LAT(RD_LAT), .KW(KW)) u_pipe (
    .clk       (clk_in),
    .rst_n     (rst_in),
    .in_valid  (issue),
    .in_k      (k),
    .out_valid (p_valid),
    .out_k     (p_k)
  );

  assign bus.req_ready = (state == IDLE);
  assign bus.a_rd_en   = issue && !a_oob;
  assign bus.b_rd_en   = issue && !b_oob;
  assign bus.a_addr    = issue ? AW'({row_q, k}) : '0;
  assign bus.b_addr    = issue ? AW'({k, col_q[KW-1:0]}) : '0;
  assign bus.val_rows  = (state == RESP);
  assign bus.matA_row  = a_vec;
  assign bus.matB_col  = b_vec;
  assign bus.row_resp  = row_tag;
  assign bus.col_resp  = col_tag;
endmodule

// File: tb/tb_matrix_fetch.sv
// tb/tb_matrix_fetch.sv - scoreboard bench for matrix_fetch with latency-2 BRAM models.
module tb_matrix_fetch;
  import matrix_pkg::*;

  localparam int RD_LAT = 2;
  localparam int RESP_CYC = N + RD_LAT + 1;

  typedef struct {
    int   row;
    int   col;
    vec_t a;
    vec_t b;
    int   due;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   val_cnt = 0;
  int   a_rd_cnt = 0;
  exp_t sb[$];

  elem_t mem_a [0:1023];
  elem_t mem_b [0:1023];
  elem_t a_p1, a_p2, b_p1, b_p2;

  matrix_fetch_if bus();

  matrix_fetch #(.RD_LAT(RD_LAT)) dut (
    .clk_in (clk),
    .rst_in (rst_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk) begin
    a_p1 <= bus.a_rd_en ? mem_a[bus.a_addr] : 8'hEE;
    b_p1 <= bus.b_rd_en ? mem_b[bus.b_addr] : 8'hEE;
    a_p2 <= a_p1;
    b_p2 <= b_p1;
  end
  assign bus.a_data = a_p2;
  assign bus.b_data = b_p2;

  task automatic chk(input string tag, input logic [N*DW-1:0] obs, input logic [N*DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.a_rd_en) a_rd_cnt++;
    if (rst_n && bus.val_rows) begin
      val_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_val: observed val_rows=1 at cycle %0d expected no response", cyc);
      end
      if (sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("val_cycle", cyc, e.due);
        chk("row_resp", bus.row_resp, e.row);
        chk("col_resp", bus.col_resp, e.col);
        chk("matA_row", bus.matA_row, e.a);
        chk("matB_col", bus.matB_col, e.b);
      end
    end
  end

  function automatic void push(input int r, input int c);
    exp_t e;
    e.row = r;
    e.col = c;
    for (int k = 0; k < N; k++) begin
      e.a[k] = (r < N) ? mem_a[(r*N + k) % 1024] : '0;
      e.b[k] = (c < N) ? mem_b[(k*N + c) % 1024] : '0;
    end
    e.due = cyc + RESP_CYC;
    sb.push_back(e);
  endfunction

  task automatic wait_ready();
    int t = 0;
    while (!bus.req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    chk("req_ready_wait", bus.req_ready, 1'b1);
  endtask

  task automatic send(input int r, input int c, input bit expect_resp);
    @(negedge clk);
    wait_ready();
    bus.new_request = 1'b1;
    bus.row_req = IDXW'(r);
    bus.col_req = IDXW'(c);
    if (expect_resp) push(r, c);
    @(negedge clk);
    bus.new_request = 1'b0;
  endtask

  task automatic wait_done();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    chk("scoreboard_drained", sb.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_val_rows"}, bus.val_rows, 1'b0);
    chk({tag, "_a_rd_en"}, bus.a_rd_en, 1'b0);
    chk({tag, "_b_rd_en"}, bus.b_rd_en, 1'b0);
    chk({tag, "_a_addr"}, bus.a_addr, '0);
    chk({tag, "_matA_row"}, bus.matA_row, '0);
    chk({tag, "_matB_col"}, bus.matB_col, '0);
    chk({tag, "_row_resp"}, bus.row_resp, '0);
    chk({tag, "_col_resp"}, bus.col_resp, '0);
  endtask

  initial begin
    int v0, c0, r0;
    bus.new_request = 1'b0;
    bus.row_req = '0;
    bus.col_req = '0;
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mem_a[r*N + c] = elem_t'(r*N + c);
        mem_b[r*N + c] = elem_t'(c + 1);
      end

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst_n = 1'b1;
    @(negedge clk);
    chk("req_ready_after_reset", bus.req_ready, 1'b1);

    // Basic fetch: A row 2 = 64..95, B column 5 = all 6.
    v0 = val_cnt;
    send(2, 5, 1'b1);
    wait_done();
    chk("single_pulse_basic", val_cnt - v0, 1);

    // Identity B, all-ones A.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) begin
        mem_a[r*N + c] = 8'h01;
        mem_b[r*N + c] = (r == c) ? 8'h01 : 8'h00;
      end
    send(3, 0, 1'b1);
    wait_done();

    // Out-of-range row: no A reads, zeros in matA_row, B still correct.
    r0 = a_rd_cnt;
    send(40, 3, 1'b1);
    wait_done();
    chk("oob_a_rd_en_count", a_rd_cnt - r0, 0);

    // Requests while busy are ignored.
    for (int r = 0; r < N; r++)
      for (int c = 0; c < N; c++) mem_a[r*N + c] = elem_t'(r*N + c + 3);
    v0 = val_cnt;
    send(7, 9, 1'b1);
    for (int i = 0; i < 6; i++) begin
      bus.new_request = 1'b1;
      bus.row_req = IDXW'(i + 1);
      bus.col_req = IDXW'(2*i);
      @(negedge clk);
      bus.new_request = 1'b0;
      repeat (4) @(negedge clk);
    end
    wait_done();
    repeat (40) @(negedge clk);
    chk("busy_single_pulse", val_cnt - v0, 1);

    // Reset at cycle 12 of a fetch; the aborted request must never respond.
    v0 = val_cnt;
    @(negedge clk);
    wait_ready();
    bus.new_request = 1'b1;
    bus.row_req = IDXW'(6);
    bus.col_req = IDXW'(6);
    c0 = cyc;
    @(negedge clk);
    bus.new_request = 1'b0;
    while (cyc < c0 + 12) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check_reset_outputs("midreset");
    @(negedge clk);
    rst_n = 1'b1;
    send(1, 1, 1'b1);
    wait_done();
    repeat (40) @(negedge clk);
    chk("midreset_single_pulse", val_cnt - v0, 1);

    // new_request held high: responses 36 cycles apart.
    @(negedge clk);
    wait_ready();
    bus.new_request = 1'b1;
    for (int i = 0; i < 3; i++) begin
      wait_ready();
      bus.row_req = IDXW'(10 + i);
      bus.col_req = IDXW'(20 + i);
      push(10 + i, 20 + i);
      @(negedge clk);
    end
    bus.new_request = 1'b0;
    wait_done();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
